// File: rtl/sram_arbiter.sv
// Two-master (fetch / MEM-stage) arbiter onto a single-port synchronous SRAM.
// Data normally wins; a starvation counter forces an inst grant after STARVE_MAX losses.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [15:0] conflict_cnt
);

  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  logic [SW-1:0] starve_q, starve_d;
  logic          resp_i_q, resp_i_d;
  logic          resp_d_q, resp_d_d;
  logic [31:0]   inst_hold_q, inst_hold_d;
  logic [31:0]   data_hold_q, data_hold_d;
  logic [CW-1:0] conflict_q, conflict_d;
  logic          gnt_i_c, gnt_d_c;

  // Grants are qualified by resetn so nothing reaches the SRAM while in reset.
  always_comb begin
    gnt_d_c = 1'b0;
    gnt_i_c = 1'b0;
    if (resetn) begin
      gnt_d_c = data_req & ~(inst_req & (starve_q == STARVE_LIM));
      gnt_i_c = inst_req & ~gnt_d_c;
    end
  end

  always_comb begin
    starve_d    = '0;
    resp_i_d    = gnt_i_c;
    resp_d_d    = gnt_d_c;
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
    conflict_d  = conflict_q;

    if (inst_req && !gnt_i_c) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + SW'(1);
    end
    if (resp_i_q) inst_hold_d = sram_rdata;
    if (resp_d_q) data_hold_d = sram_rdata;
    if (inst_req && data_req && (conflict_q != CNT_MAX)) begin
      conflict_d = conflict_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q    <= '0;
      resp_i_q    <= 1'b0;
      resp_d_q    <= 1'b0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
      conflict_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      resp_i_q    <= resp_i_d;
      resp_d_q    <= resp_d_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
      conflict_q  <= conflict_d;
    end
  end

  // SRAM command side and response side.
  always_comb begin
    inst_addr_ok = gnt_i_c;
    data_addr_ok = gnt_d_c;
    sram_en      = gnt_i_c | gnt_d_c;
    sram_addr    = gnt_d_c ? data_addr : inst_addr;
    sram_wdata   = data_wdata;
    sram_we      = (gnt_d_c && data_wr) ? data_wstrb : 4'b0000;
    inst_data_ok = resp_i_q;
    data_data_ok = resp_d_q;
    inst_rdata   = resp_i_q ? sram_rdata : inst_hold_q;
    data_rdata   = resp_d_q ? sram_rdata : data_hold_q;
    conflict_cnt = conflict_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (STARVE_MAX = 3).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  logic        use_mem;
  logic [31:0] rdata_drv;
  logic [31:0] mem_q;

  sram_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Simple SRAM model: read data is a fixed function of the address, valid next cycle.
  always_ff @(posedge clk) begin
    if (sram_en) mem_q <= sram_addr ^ 32'hA5A5_0000;
  end
  assign sram_rdata = use_mem ? mem_q : rdata_drv;

  task automatic idle();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    use_mem = 1'b0; rdata_drv = 32'h0;
    resetn = 1'b0;
    #2;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_we, inst_data_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ao_i=%b ao_d=%b en=%b we=%b dok_i=%b dok_d=%b, want all 0",
               inst_addr_ok, data_addr_ok, sram_en, sram_we, inst_data_ok, data_data_ok);
    end
    checks++;
    if (conflict_cnt !== 16'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%h irdata=%h drdata=%h, want 0/0/0",
               conflict_cnt, inst_rdata, data_rdata);
    end
    do_reset();
  endtask

  task automatic test_inst_read();
    idle();
    inst_req = 1'b1; inst_addr = 32'h100;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || sram_en !== 1'b1 ||
        sram_addr !== 32'h100 || sram_we !== 4'b0) begin
      errors++;
      $display("FAIL inst_grant: got ao_i=%b ao_d=%b en=%b addr=%h we=%b, want 1 0 1 00000100 0000",
               inst_addr_ok, data_addr_ok, sram_en, sram_addr, sram_we);
    end
    @(posedge clk); #1;
    idle();
    rdata_drv = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF || inst_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL inst_resp: got dok=%b rdata=%h ao=%b, want 1 deadbeef 0",
               inst_data_ok, inst_rdata, inst_addr_ok);
    end
    @(posedge clk); #1;
    rdata_drv = 32'h0;
    #1;
    checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL inst_hold: got dok=%b rdata=%h, want 0 deadbeef", inst_data_ok, inst_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    idle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h200; data_wdata = 32'h1234_ABCD;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || sram_en !== 1'b1 ||
        sram_we !== 4'b0011 || sram_addr !== 32'h200 || sram_wdata !== 32'h1234_ABCD) begin
      errors++;
      $display("FAIL store_grant: got ao=%b en=%b we=%b addr=%h wdata=%h, want 1 1 0011 00000200 1234abcd",
               data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata);
    end
    @(posedge clk); #1;
    idle();
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: got dok_d=%b dok_i=%b en=%b, want 1 0 0",
               data_data_ok, inst_data_ok, sram_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic [7:0] inst_wins;
    do_reset();
    inst_wins = 8'b1000_1000;  // D,D,D,I,D,D,D,I
    inst_req = 1'b1; inst_addr = 32'h400;
    data_req = 1'b1; data_addr = 32'h800;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (inst_addr_ok !== inst_wins[k] || data_addr_ok !== ~inst_wins[k] ||
          sram_addr !== (inst_wins[k] ? 32'h400 : 32'h800)) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got ao_i=%b ao_d=%b addr=%h, want ao_i=%b",
                 k, inst_addr_ok, data_addr_ok, sram_addr, inst_wins[k]);
      end
      checks++;
      if (conflict_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL starve_conflict[%0d]: got %0d want %0d", k, conflict_cnt, k);
      end
      @(posedge clk); #1;
    end
    idle();
    #1;
    checks++;
    if (conflict_cnt !== 16'd8 || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL starve_end: got cnt=%0d dok_i=%b dok_d=%b, want 8 1 0",
               conflict_cnt, inst_data_ok, data_data_ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_addr;
    logic        prev_inst;
    do_reset();
    use_mem = 1'b1;
    prev_addr = '0; prev_inst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k % 2 == 0) begin
        inst_req = 1'b1; inst_addr = 32'h1000 + 32'(k * 4);
      end else begin
        data_req = 1'b1; data_addr = 32'h2000 + 32'(k * 4);
      end
      #1;
      checks++;
      if (sram_en !== 1'b1 || inst_addr_ok !== (k % 2 == 0) || data_addr_ok !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got en=%b ao_i=%b ao_d=%b", k, sram_en, inst_addr_ok, data_addr_ok);
      end
      if (k > 0) begin
        checks++;
        if (inst_data_ok !== prev_inst || data_data_ok !== ~prev_inst ||
            (prev_inst ? inst_rdata : data_rdata) !== (prev_addr ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL b2b_resp[%0d]: got dok_i=%b dok_d=%b irdata=%h drdata=%h, want data %h",
                   k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, prev_addr ^ 32'hA5A5_0000);
        end
      end
      prev_inst = (k % 2 == 0);
      prev_addr = prev_inst ? inst_addr : data_addr;
      @(posedge clk); #1;
    end
    idle();
    #1;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== (32'h2014 ^ 32'hA5A5_0000) ||
        inst_rdata !== (32'h1010 ^ 32'hA5A5_0000)) begin
      errors++;
      $display("FAIL b2b_last: got dok_d=%b drdata=%h irdata=%h", data_data_ok, data_rdata, inst_rdata);
    end
    @(posedge clk); #1;
    use_mem = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h300;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1 || sram_we !== 4'hF) begin
      errors++;
      $display("FAIL mid_grant: got ao_d=%b we=%b, want 1 1111", data_addr_ok, sram_we);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_we, inst_data_ok, data_data_ok} !== 9'b0 ||
        conflict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: got ao_i=%b ao_d=%b en=%b we=%b dok_d=%b cnt=%0d, want all 0",
               inst_addr_ok, data_addr_ok, sram_en, sram_we, data_data_ok, conflict_cnt);
    end
    idle();
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
        errors++;
        $display("FAIL mid_after[%0d]: got dok_d=%b dok_i=%b, want 0 0", k, data_data_ok, inst_data_ok);
      end
    end
  endtask

  task automatic test_conflict_sat();
    do_reset();
    inst_req = 1'b1; data_req = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (conflict_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: got %h want fffe", conflict_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hit: got %h want ffff", conflict_cnt);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", conflict_cnt);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_store();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();
    test_conflict_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
